game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter STEP, default 2, player displacement in pixels per frame_tick.
REQ-002 Parameter BORDER, default 15, width of the playfield frame in pixels; the 640x480 screen is fixed.
REQ-003 clk_d  input  1  pixel clock; all state advances on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 frame_tick  input  1  one-cycle pulse per frame, issued at start of vertical blanking.
REQ-006 btn_start, btn_pause  input  1 each  already-synchronised levels; edge-detected internally.
REQ-007 btn_up, btn_down, btn_left, btn_right  input  1 each  movement levels.
REQ-008 x, y  output  10 each  player centre; r  output  6  player radius, always in {10,20,30,40,50}.
REQ-009 E1x, E1y, E2x, E2y, E3x, E3y  output  10 each  enemy centres; enemy radius is fixed at 10.
REQ-010 gamemenu, gamerun, gamepause  output  1 each  one-hot state flags.
REQ-011 score  output  8  count of enemies eaten since the last game start; saturates at 255.

Function
REQ-012 FSM states: MENU, RUN, PAUSE; each flag is registered and equals 1 exactly in its own state.
REQ-013 Button edge = level high and previous-cycle level low; the previous-level registers reset to 1, so a button held through reset produces no edge.
REQ-014 Transitions: MENU + start edge -> RUN with INIT; RUN + pause edge -> PAUSE; PAUSE + pause edge -> RUN; PAUSE + start edge -> MENU; start and pause edges in the same cycle: start has priority.
REQ-015 INIT loads x=320, y=240, r=10, E1=(120,120), E2=(520,120), E3=(320,400), score=0, in the same cycle as the state change.
REQ-016 Movement: only in RUN, on frame_tick; registered at T+1. Opposing buttons both high: no motion on that axis.
REQ-017 Clamp after the step: x-r >= BORDER, x+r <= 639-BORDER, y-r >= BORDER, y+r <= 479-BORDER. A step that crosses a limit lands exactly on the limit.
REQ-018 Collision stage: at T+1, compute dx = x - Ex as 11-bit signed value. Hit when dx^2 + dy^2 <= (r+10)^2. Use unsigned 20-bit sums; no truncation is permitted. Register the hit flags.
REQ-019 At T+2, at most one enemy is eaten, priority E1 > E2 > E3. r += 10, saturating at 50; score += 1, saturating. The eaten enemy relocates to Ex = 40 + lfsr[8:0], Ey = 60 + lfsr[15:8].
REQ-020 Eat while r is already 50 = win: state returns to MENU at T+2; positions, r and score hold until the next INIT.
REQ-021 16-bit Fibonacci LFSR with taps 16,14,13,11 shifts every clk_d cycle in all states; it never reaches zero.
REQ-022 frame_tick outside RUN, or a pause edge at T or T+1: any pending update of the T+1/T+2 pipeline is discarded. Game state is frozen.
REQ-023 All outputs are registered; between updates they are stable for the entire frame.

Reset
REQ-024 On rst high, immediately and asynchronously: state=MENU, flags (1,0,0), INIT values, score=0, lfsr=16'hACE1, pipeline cleared.
REQ-025 Reset asserted mid-pipeline discards all pending moves and hits; the first frame_tick after release is processed normally.

Configuration
REQ-026 Macro GAME_CTRL_ENEMY_DRIFT_EN.
- Defined: in RUN, on each frame_tick, every enemy moves 1 px diagonally. A direction bit per axis reverses when the centre reaches 25 or 614 (x), or 25 or 454 (y). Direction bits reset to +x, +y.
- Undefined: enemies move only on relocation.

Verification
REQ-027 Reset, then start edge -> gamerun=1 next cycle; x=320, y=240, r=10, score=0.
REQ-028 RUN, btn_right held for 200 frame_ticks, STEP=2 -> x stops at 614 (624-10); y unchanged at 240.
REQ-029 E1 placed at (330,240) with player at (320,240), r=10, then frame_tick -> at T+2 r=20, score=1, E1 relocated inside [40,551]x[60,315].
REQ-030 Pause edge in RUN -> gamepause=1; 5 frame_ticks with btn_left held -> x unchanged. Second pause edge -> RUN.
REQ-031 start and pause edges together in PAUSE -> MENU. rst pulse mid-RUN -> flags (1,0,0) asynchronously, before the next clk_d edge.
REQ-032 r=50 and a hit -> gamemenu=1 at T+2; r stays 50; score increments.

Source files
------------

// File: rtl/game_ctrl.sv
// Game controller: MENU/RUN/PAUSE FSM, clamped player movement, two-stage collision/eat
// pipeline and LFSR enemy relocation. Define GAME_CTRL_ENEMY_DRIFT_EN for diagonally drifting enemies.
module game_ctrl #(
  parameter int unsigned STEP   = 2,
  parameter int unsigned BORDER = 15
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [5:0] r,
  output logic [9:0] E1x,
  output logic [9:0] E1y,
  output logic [9:0] E2x,
  output logic [9:0] E2y,
  output logic [9:0] E3x,
  output logic [9:0] E3y,
  output logic       gamemenu,
  output logic       gamerun,
  output logic       gamepause,
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  localparam logic [9:0]  INIT_X         = 10'd320;
  localparam logic [9:0]  INIT_Y         = 10'd240;
  localparam logic [9:0]  INIT_EX [3]    = '{10'd120, 10'd520, 10'd320};
  localparam logic [9:0]  INIT_EY [3]    = '{10'd120, 10'd120, 10'd400};
  localparam logic [5:0]  R_MIN          = 6'd10;
  localparam logic [5:0]  R_MAX          = 6'd50;
  localparam logic [5:0]  R_INC          = 6'd10;
  localparam logic [9:0]  RELOC_X0       = 10'd40;
  localparam logic [9:0]  RELOC_Y0       = 10'd60;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
  localparam int          SCREEN_X_LAST  = 639;
  localparam int          SCREEN_Y_LAST  = 479;
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
  localparam logic [9:0]  DRIFT_LO       = 10'd25;
  localparam logic [9:0]  DRIFT_X_HI     = 10'd614;
  localparam logic [9:0]  DRIFT_Y_HI     = 10'd454;
`endif

  state_e      state_q, state_d;
  logic        menu_q, menu_d, run_q, run_d, pause_q, pause_d;
  logic        start_prev_q, pause_prev_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  r_q, r_d;
  logic [7:0]  score_q, score_d;
  logic [9:0]  ex_q [3];
  logic [9:0]  ex_d [3];
  logic [9:0]  ey_q [3];
  logic [9:0]  ey_d [3];
  logic [15:0] lfsr_q, lfsr_d;
  logic        chk_q, chk_d;
  logic [2:0]  hit_q, hit_d;
  logic        start_edge, pause_edge;
  logic        do_init;
  logic [1:0]  eat_idx;
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
  logic [2:0]  dirx_q, dirx_d, diry_q, diry_d;
`endif

  assign start_edge = btn_start & ~start_prev_q;
  assign pause_edge = btn_pause & ~pause_prev_q;

  // Step one axis, then pull the centre back inside the frame for the current radius.
  function automatic logic [9:0] clamp_step(input logic [9:0] pos, input logic fwd,
                                            input logic back, input logic [5:0] rad,
                                            input int lim);
    int p, lo, hi;
    p = int'(pos);
    if (fwd && !back)      p = p + int'(STEP);
    else if (back && !fwd) p = p - int'(STEP);
    lo = int'(BORDER) + int'(rad);
    hi = lim - int'(BORDER) - int'(rad);
    if (p < lo)      p = lo;
    else if (p > hi) p = hi;
    return p[9:0];
  endfunction

  function automatic logic touching(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] ex, input logic [9:0] ey,
                                    input logic [5:0] rad);
    logic signed [10:0] dx, dy;
    logic [9:0]         ax, ay;
    logic [6:0]         reach;
    logic [19:0]        d2, lim2;
    dx    = $signed({1'b0, px}) - $signed({1'b0, ex});
    dy    = $signed({1'b0, py}) - $signed({1'b0, ey});
    ax    = dx[10] ? 10'(-dx) : dx[9:0];
    ay    = dy[10] ? 10'(-dy) : dy[9:0];
    d2    = 20'(ax) * 20'(ax) + 20'(ay) * 20'(ay);
    reach = 7'(rad) + 7'd10;
    lim2  = 20'(reach) * 20'(reach);
    return d2 <= lim2;
  endfunction

  always_comb begin
    // NOTE: every signal written here is given its hold value first, so no path infers a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    score_d = score_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    chk_d   = 1'b0;
    hit_d   = 3'b000;
    do_init = 1'b0;
    eat_idx = 2'd0;
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
    dirx_d  = dirx_q;
    diry_d  = diry_q;
`endif

    unique case (state_q)
      S_MENU: begin
        if (start_edge) begin
          state_d = S_RUN;
          do_init = 1'b1;
        end
      end
      S_RUN: begin
        // A pause edge leaves RUN and drops whatever the pipeline was carrying.
        if (pause_edge) begin
          state_d = S_PAUSE;
        end else begin
          chk_d = frame_tick;
          if (chk_q) begin
            for (int k = 0; k < 3; k++) hit_d[k] = touching(x_q, y_q, ex_q[k], ey_q[k], r_q);
          end
          if (frame_tick) begin
            x_d = clamp_step(x_q, btn_right, btn_left, r_q, SCREEN_X_LAST);
            y_d = clamp_step(y_q, btn_down, btn_up, r_q, SCREEN_Y_LAST);
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
            for (int k = 0; k < 3; k++) begin
              ex_d[k] = dirx_q[k] ? ex_q[k] + 10'd1 : ex_q[k] - 10'd1;
              ey_d[k] = diry_q[k] ? ey_q[k] + 10'd1 : ey_q[k] - 10'd1;
              if (ex_d[k] >= DRIFT_X_HI) dirx_d[k] = 1'b0;
              if (ex_d[k] <= DRIFT_LO)   dirx_d[k] = 1'b1;
              if (ey_d[k] >= DRIFT_Y_HI) diry_d[k] = 1'b0;
              if (ey_d[k] <= DRIFT_LO)   diry_d[k] = 1'b1;
            end
`endif
          end
          if (|hit_q) begin
            eat_idx          = hit_q[0] ? 2'd0 : (hit_q[1] ? 2'd1 : 2'd2);
            ex_d[eat_idx]    = RELOC_X0 + 10'(lfsr_q[8:0]);
            ey_d[eat_idx]    = RELOC_Y0 + 10'(lfsr_q[15:8]);
            score_d          = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            if (r_q >= R_MAX) state_d = S_MENU;
            else              r_d     = r_q + R_INC;
          end
        end
      end
      S_PAUSE: begin
        if (start_edge)      state_d = S_MENU;
        else if (pause_edge) state_d = S_RUN;
      end
      default: state_d = S_MENU;
    endcase

    if (do_init) begin
      x_d     = INIT_X;
      y_d     = INIT_Y;
      r_d     = R_MIN;
      score_d = '0;
      ex_d    = INIT_EX;
      ey_d    = INIT_EY;
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
      dirx_d  = '1;
      diry_d  = '1;
`endif
    end

    menu_d  = (state_d == S_MENU);
    run_d   = (state_d == S_RUN);
    pause_d = (state_d == S_PAUSE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_q      <= S_MENU;
      menu_q       <= 1'b1;
      run_q        <= 1'b0;
      pause_q      <= 1'b0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      x_q          <= INIT_X;
      y_q          <= INIT_Y;
      r_q          <= R_MIN;
      score_q      <= '0;
      // NOTE: the enemy arrays are six ordinary flops, not a RAM, so they take reset like any other state.
      ex_q         <= INIT_EX;
      ey_q         <= INIT_EY;
      lfsr_q       <= LFSR_SEED;
      chk_q        <= 1'b0;
      hit_q        <= 3'b000;
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
      dirx_q       <= '1;
      diry_q       <= '1;
`endif
    end else begin
      state_q      <= state_d;
      menu_q       <= menu_d;
      run_q        <= run_d;
      pause_q      <= pause_d;
      start_prev_q <= btn_start;
      pause_prev_q <= btn_pause;
      x_q          <= x_d;
      y_q          <= y_d;
      r_q          <= r_d;
      score_q      <= score_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      lfsr_q       <= lfsr_d;
      chk_q        <= chk_d;
      hit_q        <= hit_d;
`ifdef GAME_CTRL_ENEMY_DRIFT_EN
      dirx_q       <= dirx_d;
      diry_q       <= diry_d;
`endif
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign r         = r_q;
  assign score     = score_q;
  assign E1x       = ex_q[0];
  assign E1y       = ey_q[0];
  assign E2x       = ex_q[1];
  assign E2y       = ey_q[1];
  assign E3x       = ex_q[2];
  assign E3y       = ey_q[2];
  assign gamemenu  = menu_q;
  assign gamerun   = run_q;
  assign gamepause = pause_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random play, every output compared
// each cycle against a behavioural game model.
module tb_game_ctrl;

  localparam int STEP   = 2;
  localparam int BORDER = 15;

  logic       clk_d = 1'b0;
  logic       rst, frame_tick;
  logic       btn_start, btn_pause, btn_up, btn_down, btn_left, btn_right;
  logic [9:0] x, y, E1x, E1y, E2x, E2y, E3x, E3y;
  logic [5:0] r;
  logic [7:0] score;
  logic       gamemenu, gamerun, gamepause;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_d = ~clk_d;

  game_ctrl #(.STEP(STEP), .BORDER(BORDER)) dut (
    .clk_d(clk_d), .rst(rst), .frame_tick(frame_tick),
    .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x(x), .y(y), .r(r),
    .E1x(E1x), .E1y(E1y), .E2x(E2x), .E2y(E2y), .E3x(E3x), .E3y(E3y),
    .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause), .score(score)
  );

  // Game model: what the player should see, frame by frame, in plain integers.
  typedef enum int {M_MENU, M_RUN, M_PAUSE} mode_t;
  mode_t m_mode;
  int    m_x, m_y, m_r, m_score, m_lfsr, m_last_eat;
  int    m_ex [3];
  int    m_ey [3];
  bit    m_prev_start, m_prev_pause;
  bit    m_look;
  bit    m_bite [3];

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 'hFFFF) | fb;
  endfunction

  function automatic int m_clamp(input int pos, input logic fwd, input logic back, input int last);
    int p;
    p = pos;
    if (fwd && !back) p = p + STEP;
    if (back && !fwd) p = p - STEP;
    if (p < BORDER + m_r) p = BORDER + m_r;
    if (p > last - BORDER - m_r) p = last - BORDER - m_r;
    return p;
  endfunction

  function automatic bit m_touch(input int k);
    int dx, dy, reach;
    dx    = m_x - m_ex[k];
    dy    = m_y - m_ey[k];
    reach = m_r + 10;
    return (dx * dx + dy * dy) <= reach * reach;
  endfunction

  task automatic model_init();
    m_x = 320; m_y = 240; m_r = 10; m_score = 0;
    m_ex = '{120, 520, 320};
    m_ey = '{120, 120, 400};
  endtask

  task automatic model_reset();
    model_init();
    m_mode = M_MENU;
    m_lfsr = 'hACE1;
    m_prev_start = 1'b1;
    m_prev_pause = 1'b1;
    m_look = 1'b0;
    m_bite = '{0, 0, 0};
  endtask

  task automatic model_step();
    int lf, k_eat;
    bit se, pe, look_next;
    bit bite_next [3];
    lf = m_lfsr;
    se = btn_start && !m_prev_start;
    pe = btn_pause && !m_prev_pause;
    m_prev_start = btn_start;
    m_prev_pause = btn_pause;
    m_lfsr = lfsr_next(lf);
    bite_next = '{0, 0, 0};
    look_next = 1'b0;
    case (m_mode)
      M_MENU: if (se) begin model_init(); m_mode = M_RUN; end
      M_PAUSE: begin
        if (se)      m_mode = M_MENU;
        else if (pe) m_mode = M_RUN;
      end
      default: begin
        if (pe) begin
          m_mode = M_PAUSE;
        end else begin
          if (m_look) for (int k = 0; k < 3; k++) bite_next[k] = m_touch(k);
          k_eat = -1;
          for (int k = 2; k >= 0; k--) if (m_bite[k]) k_eat = k;
          if (frame_tick) begin
            m_x = m_clamp(m_x, btn_right, btn_left, 639);
            m_y = m_clamp(m_y, btn_down, btn_up, 479);
          end
          if (k_eat >= 0) begin
            m_ex[k_eat] = 40 + (lf & 'h1FF);
            m_ey[k_eat] = 60 + ((lf >> 8) & 'hFF);
            if (m_score < 255) m_score++;
            if (m_r == 50) m_mode = M_MENU;
            else           m_r += 10;
            m_last_eat = k_eat;
          end
          look_next = frame_tick;
        end
      end
    endcase
    m_bite = bite_next;
    m_look = look_next;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic compare_all();
    chk("gamemenu", 32'(gamemenu), 32'(m_mode == M_MENU));
    chk("gamerun", 32'(gamerun), 32'(m_mode == M_RUN));
    chk("gamepause", 32'(gamepause), 32'(m_mode == M_PAUSE));
    chk("x", 32'(x), m_x);
    chk("y", 32'(y), m_y);
    chk("r", 32'(r), m_r);
    chk("score", 32'(score), m_score);
    chk("E1x", 32'(E1x), m_ex[0]);
    chk("E1y", 32'(E1y), m_ey[0]);
    chk("E2x", 32'(E2x), m_ex[1]);
    chk("E2y", 32'(E2y), m_ey[1]);
    chk("E3x", 32'(E3x), m_ex[2]);
    chk("E3y", 32'(E3y), m_ey[2]);
  endtask

  // Inputs are set after a falling edge; the model advances, then outputs are read at the next falling edge.
  task automatic cycle();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk_d);
    @(negedge clk_d);
    compare_all();
  endtask

  task automatic frame(input int gap);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic pulse_start();
    btn_start = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    btn_start = 1'b0;
  endtask

  task automatic pulse_pause();
    btn_pause = 1'b0; cycle();
    btn_pause = 1'b1; cycle();
    btn_pause = 1'b0;
  endtask

  task automatic goto_run();
    if (m_mode == M_PAUSE) pulse_pause();
    else if (m_mode == M_MENU) pulse_start();
  endtask

  task automatic steer_to_nearest();
    int best, bd, d;
    best = 0; bd = 32'h7FFFFFFF;
    for (int k = 0; k < 3; k++) begin
      d = (m_x - m_ex[k]) * (m_x - m_ex[k]) + (m_y - m_ey[k]) * (m_y - m_ey[k]);
      if (d < bd) begin bd = d; best = k; end
    end
    btn_left  = (m_x > m_ex[best]);
    btn_right = (m_x < m_ex[best]);
    btn_up    = (m_y > m_ey[best]);
    btn_down  = (m_y < m_ey[best]);
  endtask

  function automatic int dut_ex(input int k);
    return (k == 0) ? int'(E1x) : (k == 1) ? int'(E2x) : int'(E3x);
  endfunction

  function automatic int dut_ey(input int k);
    return (k == 0) ? int'(E1y) : (k == 1) ? int'(E2y) : int'(E3y);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; frame_tick = 1'b0;
    btn_start = 1'b1; btn_pause = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    m_last_eat = 0;
    model_reset();
    cycle(); cycle();
    chk("reset_flags", 32'({gamemenu, gamerun, gamepause}), 32'b100);

    // Start held through reset must not count as an edge.
    rst = 1'b0;
    repeat (3) cycle();
    chk("held_start_no_edge", 32'(gamemenu), 1);

    pulse_start();
    chk("start_run", 32'(gamerun), 1);
    chk("init_x", 32'(x), 320);
    chk("init_y", 32'(y), 240);
    chk("init_r", 32'(r), 10);
    chk("init_score", 32'(score), 0);

    btn_right = 1'b1;
    repeat (200) frame(5);
    btn_right = 1'b0;
    chk("right_wall_x", 32'(x), 614);
    chk("right_wall_y", 32'(y), 240);

    pulse_pause();
    cycle();
    chk("pause_flag", 32'(gamepause), 1);
    btn_left = 1'b1;
    repeat (5) frame(5);
    btn_left = 1'b0;
    chk("paused_x_frozen", 32'(x), 614);
    pulse_pause();
    cycle();
    chk("resume_run", 32'(gamerun), 1);

    // Chase enemies: first eat, then grow to the maximum radius, then the winning eat.
    for (int target = 1; target <= 4; target++) begin
      n = 0;
      while (m_score < target && m_mode == M_RUN && n < 400) begin
        steer_to_nearest();
        frame(5);
        n++;
      end
      chk("chase_score", 32'(score), target);
      chk("chase_radius", 32'(r), 10 + 10 * target);
      chk("reloc_x_range", 32'(dut_ex(m_last_eat) >= 40 && dut_ex(m_last_eat) <= 551), 1);
      chk("reloc_y_range", 32'(dut_ey(m_last_eat) >= 60 && dut_ey(m_last_eat) <= 315), 1);
    end
    n = 0;
    while (m_mode == M_RUN && n < 400) begin
      steer_to_nearest();
      frame(5);
      n++;
    end
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    chk("win_menu", 32'(gamemenu), 1);
    chk("win_r", 32'(r), 50);
    chk("win_score", 32'(score), 5);
    btn_right = 1'b1;
    repeat (4) frame(5);
    btn_right = 1'b0;

    // Random play: random levels, frame ticks, pause and start edges in any phase.
    for (int i = 0; i < 4000; i++) begin
      frame_tick = ($urandom_range(0, 4) == 0);
      btn_up     = $urandom_range(0, 1) == 1;
      btn_down   = $urandom_range(0, 1) == 1;
      btn_left   = $urandom_range(0, 1) == 1;
      btn_right  = $urandom_range(0, 1) == 1;
      btn_pause  = ($urandom_range(0, 40) == 0);
      btn_start  = ($urandom_range(0, 80) == 0);
      cycle();
    end
    frame_tick = 1'b0; btn_pause = 1'b0; btn_start = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    cycle();

    goto_run();
    pulse_pause();
    chk("pause_again", 32'(gamepause), 1);
    btn_start = 1'b1; btn_pause = 1'b1;
    cycle();
    btn_start = 1'b0; btn_pause = 1'b0;
    chk("start_beats_pause", 32'({gamemenu, gamerun, gamepause}), 32'b100);

    // Reset mid-pipeline: asserted between clock edges, flags must drop before the next edge.
    goto_run();
    btn_right = 1'b1;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    chk("async_reset_flags", 32'({gamemenu, gamerun, gamepause}), 32'b100);
    @(negedge clk_d);
    cycle();
    rst = 1'b0;
    cycle();
    goto_run();
    frame(5);
    btn_right = 1'b0;
    chk("first_tick_after_reset", 32'(x), 322);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
